fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch: owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and presents the returned instruction to decode.
- Applies PC-relative branch redirects: target = redirect_base + redirect_imm. Squashes in-flight fetches on redirect.
- Sits between the branch/decode stage and the instruction memory, replacing the free-running PC + 4 loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_valid  in  1  branch taken this cycle.
- redirect_base  in  32  PC of the branch instruction.
- redirect_imm  in  32  sign-extended branch offset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address.
- imem_resp_valid  in  1  response data valid; exactly one per accepted request.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_data  out  32  held instruction.
- instr_pc  out  32  address of instr_data.
- decode_ready  in  1  decode consumes instruction.

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_DRAIN. Registers: pc, instr_data, instr_pc.
- Reset (rst==0 at an edge):
  - state=S_REQ; pc=RESET_PC.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - Takes effect from any state, including mid-fetch. An outstanding response arriving after reset is not tracked; the memory is reset by the same rst.
- Outputs:
  - imem_req_valid=1 only in S_REQ; imem_req_addr=pc.
  - instr_valid=1 only in S_HOLD.
  - A request not yet accepted may change address. Valid stays high and the address follows pc.
- S_REQ:
  - Handshake (valid&&ready) -> S_WAIT.
- S_WAIT:
  - imem_resp_valid: instr_data<=resp, instr_pc<=pc -> S_HOLD.
  - instr_valid rises the cycle after resp_valid (fetch latency = 1 + memory latency).
- S_HOLD:
  - decode_ready: pc<=pc+PC_STEP -> S_REQ.
  - Otherwise hold all outputs stable (stall).
- Redirect (redirect_valid=1) has priority over the sequential update:
  - pc <= (redirect_base + redirect_imm) with bits[1:0] forced 0. 32-bit wrap, carry discarded.
  - S_REQ, no handshake this cycle: stay S_REQ; the new address is presented next cycle.
  - S_REQ, handshake this cycle: the stale request was accepted -> S_DRAIN.
  - S_WAIT, no resp this cycle: -> S_DRAIN.
  - S_WAIT, resp same cycle: discard resp -> S_REQ.
  - S_HOLD: the instruction is dropped whether or not decode_ready is asserted; instr_valid=0 next cycle -> S_REQ.
  - S_DRAIN: pc updated, stay S_DRAIN.
- S_DRAIN:
  - Wait for the stale imem_resp_valid, discard it -> S_REQ.
- Invariants:
  - At most one outstanding request.
  - Never two responses pending.
  - pc wraps 0xFFFF_FFFC -> 0x0000_0000.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (increments on each instruction consumed: S_HOLD && decode_ready && !redirect_valid).
  - Adds squash_count[31:0] (increments on each cycle a redirect discards an instruction or a response: entry to S_DRAIN, S_WAIT discard, S_HOLD drop).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD, S_DRAIN}.
  - Localparams: INSTR_W=32, ADDR_W=32, PC_STEP default.
- Sub-module pc_next: combinational next-pc select (sequential/redirect/hold) with alignment masking. Reusable by a later prediction stage.

Test Plan:
- Reset then free run (req_ready=1, 1-cycle memory, decode_ready=1) -> addresses 0x0, 0x4, 0x8, 0xC. instr_pc matches. instr_valid one cycle after each resp.
- Decode stall: decode_ready=0 for 5 cycles in S_HOLD -> instr_valid, instr_data, instr_pc stable. No new imem_req_valid. Release -> next request at pc+4.
- Redirect in S_WAIT:
  - base=0x100, imm=0xFFFF_FFF0. The stale response is discarded.
  - The next request is 0x0F0. instr_pc=0x0F0 for the next delivered instruction.
- Redirect coinciding with resp_valid in S_WAIT, and coinciding with the request handshake in S_REQ -> respectively direct S_REQ and S_DRAIN. No stale instruction reaches decode.
- Misaligned/wrapping target: base=0xFFFF_FFFC, imm=0x6 -> fetch addr 0x0000_0000. Sequential wrap from 0xFFFF_FFFC -> 0x0.
- Reset asserted in S_WAIT and in S_HOLD -> next cycle instr_valid=0, imem_req_addr=RESET_PC. With FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DEFAULT_PC_STEP = 4;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: branch redirect, instruction-memory handshake and decode hand-off.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_base;
  logic [ADDR_W-1:0]   redirect_imm;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_W-1:0]   imem_req_addr;
  logic                imem_resp_valid;
  logic [INSTR_W-1:0]  imem_resp_data;
  logic                instr_valid;
  logic [INSTR_W-1:0]  instr_data;
  logic [ADDR_W-1:0]   instr_pc;
  logic                decode_ready;

  modport master (
    input  redirect_valid, redirect_base, redirect_imm,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, decode_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_base, redirect_imm,
    output imem_req_ready, imem_resp_valid, imem_resp_data, decode_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC select: redirect target (word aligned), sequential step, or hold.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [ADDR_W-1:0] redirect_imm,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] target;

  always_comb begin
    target  = redirect_base + redirect_imm;
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = {target[ADDR_W-1:2], 2'b00};
    end else if (advance) begin
      next_pc = pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, one outstanding imem request, squashes on redirect.
// Optional FETCH_PERF_EN adds fetch_count / squash_count performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   squash_count
`endif
);

  fetch_state_t        state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [INSTR_W-1:0]  instr_data_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                handshake;
  logic                advance;
  logic                capture;
  logic                consume;
  logic                squash;

  pc_next #(.PC_STEP(PC_STEP)) u_pc_next (
    .pc             (pc),
    .advance        (advance),
    .redirect_valid (bus.redirect_valid),
    .redirect_base  (bus.redirect_base),
    .redirect_imm   (bus.redirect_imm),
    .next_pc        (pc_n)
  );

  always_comb begin
    bus.imem_req_valid = (state == S_REQ);
    bus.imem_req_addr  = pc;
    bus.instr_valid    = (state == S_HOLD);
    bus.instr_data     = instr_data_q;
    bus.instr_pc       = instr_pc_q;
  end

  always_comb begin
    state_n   = state;
    handshake = (state == S_REQ) && bus.imem_req_ready;
    advance   = (state == S_HOLD) && bus.decode_ready;
    capture   = (state == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    consume   = advance && !bus.redirect_valid;
    // Any redirect that lands while something is fetched or held throws that work away.
    squash    = bus.redirect_valid &&
                (((state == S_REQ) && bus.imem_req_ready) ||
                 (state == S_WAIT) || (state == S_HOLD));
    unique case (state)
      S_REQ: begin
        if (handshake) state_n = bus.redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid) state_n = bus.imem_resp_valid ? S_REQ : S_DRAIN;
        else if (bus.imem_resp_valid) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (bus.redirect_valid || bus.decode_ready) state_n = S_REQ;
      end
      S_DRAIN: begin
        if (bus.imem_resp_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (capture) begin
        instr_data_q <= bus.imem_resp_data;
        instr_pc_q   <= pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (consume) fetch_count  <= fetch_count + 32'd1;
      if (squash)  squash_count <= squash_count + 32'd1;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = consume ^ squash;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl; counter checks enabled with FETCH_PERF_EN.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, squash_count;
`endif

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .squash_count (squash_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rb;
    logic [31:0] ri;
    logic        rr;
    logic        sv;
    logic [31:0] sd;
    logic        dr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_id;
    logic [31:0] e_ipc;
    logic [31:0] e_fc;
    logic [31:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic v(input logic r, input logic rdv, input logic [31:0] rb, input logic [31:0] ri,
                   input logic rr, input logic sv, input logic [31:0] sd, input logic dr,
                   input logic erv, input logic [31:0] ea, input logic eiv,
                   input logic [31:0] eid, input logic [31:0] eipc,
                   input logic [31:0] efc, input logic [31:0] esc);
    vec_t t;
    t.rst = r; t.rdv = rdv; t.rb = rb; t.ri = ri; t.rr = rr; t.sv = sv; t.sd = sd; t.dr = dr;
    t.e_rv = erv; t.e_addr = ea; t.e_iv = eiv; t.e_id = eid; t.e_ipc = eipc;
    t.e_fc = efc; t.e_sc = esc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic rdv, input logic [31:0] rb, input logic [31:0] ri,
                       input logic rr, input logic sv, input logic [31:0] sd, input logic dr);
    rst = r;
    bus.redirect_valid = rdv; bus.redirect_base = rb; bus.redirect_imm = ri;
    bus.imem_req_ready = rr; bus.imem_resp_valid = sv; bus.imem_resp_data = sd;
    bus.decode_ready = dr;
  endtask

  initial begin
    bit got;
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);

    //  rst rdv base          imm           rr sv data          dr | rv addr          iv data          ipc           fc sc
    v(0, 0, 0,            0,            0, 0, 0,            0,   1, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    v(1, 0, 0,            0,            0, 1, 32'hA0,       0,   0, 32'h0,        1, 32'hA0,       32'h0,        0, 0);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h4,        0, 32'hA0,       32'h0,        1, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h4,        0, 32'hA0,       32'h0,        1, 0);
    v(1, 0, 0,            0,            0, 1, 32'hA4,       0,   0, 32'h4,        1, 32'hA4,       32'h4,        1, 0);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h8,        0, 32'hA4,       32'h4,        2, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h8,        0, 32'hA4,       32'h4,        2, 0);
    v(1, 0, 0,            0,            0, 1, 32'hA8,       0,   0, 32'h8,        1, 32'hA8,       32'h8,        2, 0);
    for (int i = 0; i < 5; i++)
      v(1, 0, 0,          0,            0, 0, 0,            0,   0, 32'h8,        1, 32'hA8,       32'h8,        2, 0);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'hC,        0, 32'hA8,       32'h8,        3, 0);
    v(1, 0, 0,            0,            0, 0, 0,            0,   1, 32'hC,        0, 32'hA8,       32'h8,        3, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'hC,        0, 32'hA8,       32'h8,        3, 0);
    v(1, 0, 0,            0,            0, 1, 32'hAC,       0,   0, 32'hC,        1, 32'hAC,       32'hC,        3, 0);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h10,       0, 32'hAC,       32'hC,        4, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h10,       0, 32'hAC,       32'hC,        4, 0);
    v(1, 1, 32'h100,      32'hFFFF_FFF0,0, 0, 0,            0,   0, 32'hF0,       0, 32'hAC,       32'hC,        4, 1);
    v(1, 0, 0,            0,            0, 0, 0,            0,   0, 32'hF0,       0, 32'hAC,       32'hC,        4, 1);
    v(1, 0, 0,            0,            0, 1, 32'hDEAD,     0,   1, 32'hF0,       0, 32'hAC,       32'hC,        4, 1);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'hF0,       0, 32'hAC,       32'hC,        4, 1);
    v(1, 0, 0,            0,            0, 1, 32'hBF0,      0,   0, 32'hF0,       1, 32'hBF0,      32'hF0,       4, 1);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'hF4,       0, 32'hBF0,      32'hF0,       5, 1);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'hF4,       0, 32'hBF0,      32'hF0,       5, 1);
    v(1, 1, 32'h200,      32'h8,        0, 1, 32'hBAD1,     0,   1, 32'h208,      0, 32'hBF0,      32'hF0,       5, 2);
    v(1, 1, 32'h300,      32'h0,        1, 0, 0,            0,   0, 32'h300,      0, 32'hBF0,      32'hF0,       5, 3);
    v(1, 1, 32'h400,      32'h4,        0, 0, 0,            0,   0, 32'h404,      0, 32'hBF0,      32'hF0,       5, 3);
    v(1, 0, 0,            0,            0, 1, 32'hBAD2,     0,   1, 32'h404,      0, 32'hBF0,      32'hF0,       5, 3);
    v(1, 1, 32'hFFFF_FFFC,32'h6,        0, 0, 0,            0,   1, 32'h0,        0, 32'hBF0,      32'hF0,       5, 3);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h0,        0, 32'hBF0,      32'hF0,       5, 3);
    v(1, 0, 0,            0,            0, 1, 32'hB00,      0,   0, 32'h0,        1, 32'hB00,      32'h0,        5, 3);
    v(1, 1, 32'hFFFF_FFF0,32'hC,        0, 0, 0,            1,   1, 32'hFFFF_FFFC,0, 32'hB00,      32'h0,        5, 4);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'hFFFF_FFFC,0, 32'hB00,      32'h0,        5, 4);
    v(1, 0, 0,            0,            0, 1, 32'hBFC,      0,   0, 32'hFFFF_FFFC,1, 32'hBFC,      32'hFFFF_FFFC,5, 4);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h0,        0, 32'hBFC,      32'hFFFF_FFFC,6, 4);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h0,        0, 32'hBFC,      32'hFFFF_FFFC,6, 4);
    v(1, 0, 0,            0,            0, 1, 32'hB00,      0,   0, 32'h0,        1, 32'hB00,      32'h0,        6, 4);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h4,        0, 32'hB00,      32'h0,        7, 4);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h4,        0, 32'hB00,      32'h0,        7, 4);
    v(0, 0, 0,            0,            0, 0, 0,            0,   1, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    v(1, 0, 0,            0,            0, 1, 32'hC00,      0,   0, 32'h0,        1, 32'hC00,      32'h0,        0, 0);
    v(1, 0, 0,            0,            0, 0, 0,            1,   1, 32'h4,        0, 32'hC00,      32'h0,        1, 0);
    v(1, 0, 0,            0,            1, 0, 0,            0,   0, 32'h4,        0, 32'hC00,      32'h0,        1, 0);
    v(1, 0, 0,            0,            0, 1, 32'hC04,      0,   0, 32'h4,        1, 32'hC04,      32'h4,        1, 0);
    v(0, 0, 0,            0,            0, 0, 0,            1,   1, 32'h0,        0, 32'h0,        32'h0,        0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].rdv, vecs[i].rb, vecs[i].ri,
            vecs[i].rr, vecs[i].sv, vecs[i].sd, vecs[i].dr);
      @(posedge clk);
      #1;
      chk("req_valid",   i, 32'(bus.imem_req_valid), 32'(vecs[i].e_rv));
      chk("req_addr",    i, bus.imem_req_addr,       vecs[i].e_addr);
      chk("instr_valid", i, 32'(bus.instr_valid),    32'(vecs[i].e_iv));
      chk("instr_data",  i, bus.instr_data,          vecs[i].e_id);
      chk("instr_pc",    i, bus.instr_pc,            vecs[i].e_ipc);
`ifdef FETCH_PERF_EN
      chk("fetch_count",  i, fetch_count,  vecs[i].e_fc);
      chk("squash_count", i, squash_count, vecs[i].e_sc);
`endif
    end

    // Three-cycle memory latency: request stays accepted, instr_valid follows the late response.
    @(negedge clk);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk("lat_req_drop", 100, 32'(bus.imem_req_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      chk("lat_no_instr", 101 + c, 32'(bus.instr_valid | bus.imem_req_valid), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (bus.instr_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk("lat_instr_valid", 110, 32'(got), 32'd1);
    chk("lat_instr_data",  111, bus.instr_data, 32'h5555_AAAA);
    chk("lat_instr_pc",    112, bus.instr_pc,   32'h0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    chk("lat_next_addr",  113, bus.imem_req_addr, 32'h4);
    chk("lat_next_valid", 114, 32'(bus.imem_req_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
